trap_controller: RTL and testbench

- Machine-mode interrupt sequencer for the RV32 core.
- Gates the interrupt sources (DMA external, WDT timer, software) with the mstatus.MIE and mie enables, and arbitrates them by fixed priority.
- Parks the core on WFI, waits for the memory stalls to drain, then issues a one-cycle trap-entry command. The CSR file uses that command to save mepc and cause and to update mstatus; the fetch stage uses it to redirect to the ISR.
- Tracks handler residency until mret.

---
 rtl/trap_pkg.sv | 30 +++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/trap_controller.sv | 154 +++++++++++++++
 tb/tb_trap_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
//   state_t   : sequencer states
//   Cause*    : 5-bit interrupt cause codes (mcause low bits)
//   McauseInt : mcause interrupt flag bit index
//   mcause()  : builds the full 32-bit mcause value from a code
package trap_pkg;

  typedef enum logic [2:0] {
    StRun,
    StWfi,
    StDrain,
    StEnter,
    StHandler
  } state_t;

  localparam logic [4:0] CauseMei = 5'd11;
  localparam logic [4:0] CauseMsi = 5'd3;
  localparam logic [4:0] CauseMti = 5'd7;

  localparam int unsigned McauseInt = 31;

  function automatic logic [31:0] mcause(input logic [4:0] code);
    logic [31:0] val;
    val            = '0;
    val[McauseInt] = 1'b1;
    val[4:0]       = code;
    return val;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: external > software > timer.
//   pe_i    : enabled external pending
//   ps_i    : enabled software pending
//   pt_i    : enabled timer pending
//   valid_o : any enabled source pending
//   code_o  : cause code of the winning source (0 when none)
module irq_prio_enc
  import trap_pkg::*;
(
  input  logic       pe_i,
  input  logic       ps_i,
  input  logic       pt_i,
  output logic       valid_o,
  output logic [4:0] code_o
);

  always_comb begin
    valid_o = pe_i | ps_i | pt_i;
    code_o  = '0;
    if (pe_i) begin
      code_o = CauseMei;
    end else if (ps_i) begin
      code_o = CauseMsi;
    end else if (pt_i) begin
      code_o = CauseMti;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode interrupt sequencer: gates and arbitrates interrupt sources, parks the core on
// WFI, waits for memory stalls to drain, then issues a one-cycle trap-entry command and tracks
// handler residency until mret.
//   clk, rst (async, active low)
//   ext_irq/tmr_irq/sw_irq      : level interrupt sources
//   mstatus_mie, mie_*          : global and per-source enables
//   im_stall/dm_stall           : memory stalls; both low means the pipeline can move
//   wfi_valid/mret_valid/exe_pc : instruction in EXE
//   trap_take/flush             : one-cycle trap-entry pulse
//   trap_cause/epc/target       : mcause, mepc and ISR fetch address for the trap
//   wfi_stall, in_trap          : sleeping / handler active
//   trap_cnt                    : wrapping count of traps taken
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [31:0] ISR_PC   = 32'h0001_0000,
  parameter bit          VECTORED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        sw_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        mie_msie,
  input  logic        im_stall,
  input  logic        dm_stall,
  input  logic        wfi_valid,
  input  logic        mret_valid,
  input  logic [31:0] exe_pc,
  output logic        trap_take,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_target,
  output logic        flush,
  output logic        wfi_stall,
  output logic        in_trap,
  output logic [31:0] trap_cnt
);

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_src_q, epc_src_d;

  logic        take_q, wfi_stall_q, in_trap_q;
  logic [31:0] cause_q, epc_q, target_q, cnt_q;

  logic        go, req, any_pend, take;
  logic [4:0]  enc_code;
  logic [31:0] target;

  irq_prio_enc u_prio (
    .pe_i    (ext_irq & mie_meie),
    .ps_i    (sw_irq & mie_msie),
    .pt_i    (tmr_irq & mie_mtie),
    .valid_o (any_pend),
    .code_o  (enc_code)
  );

  assign go   = ~im_stall & ~dm_stall;
  assign req  = any_pend & mstatus_mie;
  assign take = (state_q == StDrain) & go;

  always_comb begin
    target = ISR_PC;
    if (VECTORED) begin
      target = ISR_PC + {25'd0, code_q, 2'b00};
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    epc_src_d = epc_src_q;
    unique case (state_q)
      StRun: begin
        if (req && go) begin
          state_d   = StDrain;
          code_d    = enc_code;
          // A WFI in EXE alongside the request counts as retired.
          epc_src_d = wfi_valid ? exe_pc + 32'd4 : exe_pc;
        end else if (wfi_valid && go) begin
          state_d   = StWfi;
          epc_src_d = exe_pc + 32'd4;
        end
      end
      StWfi: begin
        // Wake ignores MIE; only a globally enabled source turns into a trap.
        if (any_pend) begin
          if (mstatus_mie) begin
            state_d = StDrain;
            code_d  = enc_code;
          end else begin
            state_d = StRun;
          end
        end
      end
      StDrain: begin
        if (go) begin
          state_d = StEnter;
        end
      end
      StEnter: begin
        state_d = StHandler;
      end
      StHandler: begin
        if (mret_valid && go) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      code_q      <= '0;
      epc_src_q   <= '0;
      take_q      <= 1'b0;
      wfi_stall_q <= 1'b0;
      in_trap_q   <= 1'b0;
      cause_q     <= '0;
      epc_q       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      epc_src_q   <= epc_src_d;
      take_q      <= take;
      wfi_stall_q <= (state_d == StWfi);
      in_trap_q   <= (state_d == StHandler);
      if (take) begin
        cause_q  <= mcause(code_q);
        epc_q    <= epc_src_q;
        target_q <= target;
        cnt_q    <= cnt_q + 32'd1;
      end
    end
  end

  assign trap_take   = take_q;
  assign flush       = take_q;
  assign trap_cause  = cause_q;
  assign trap_epc    = epc_q;
  assign trap_target = target_q;
  assign wfi_stall   = wfi_stall_q;
  assign in_trap     = in_trap_q;
  assign trap_cnt    = cnt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized stimulus, all
// compared cycle by cycle against a behavioural reference model.
module tb_trap_controller;

  localparam logic [31:0] IsrPc = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_irq = 0, tmr_irq = 0, sw_irq = 0;
  logic        mstatus_mie = 0, mie_meie = 0, mie_mtie = 0, mie_msie = 0;
  logic        im_stall = 0, dm_stall = 0, wfi_valid = 0, mret_valid = 0;
  logic [31:0] exe_pc = '0;
  logic        trap_take, flush, wfi_stall, in_trap;
  logic [31:0] trap_cause, trap_epc, trap_target, trap_cnt;

  int total = 0;
  int bad   = 0;

  trap_controller #(
    .ISR_PC   (IsrPc),
    .VECTORED (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_irq     (ext_irq),
    .tmr_irq     (tmr_irq),
    .sw_irq      (sw_irq),
    .mstatus_mie (mstatus_mie),
    .mie_meie    (mie_meie),
    .mie_mtie    (mie_mtie),
    .mie_msie    (mie_msie),
    .im_stall    (im_stall),
    .dm_stall    (dm_stall),
    .wfi_valid   (wfi_valid),
    .mret_valid  (mret_valid),
    .exe_pc      (exe_pc),
    .trap_take   (trap_take),
    .trap_cause  (trap_cause),
    .trap_epc    (trap_epc),
    .trap_target (trap_target),
    .flush       (flush),
    .wfi_stall   (wfi_stall),
    .in_trap     (in_trap),
    .trap_cnt    (trap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(wfi_valid && mret_valid)) else $error("wfi_valid and mret_valid in same cycle");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs plus a "trap owed" flag with its saved code and return pc.
  bit          e_take, e_wfi_stall, e_in_trap;
  logic [31:0] e_cause, e_epc, e_target, e_cnt;
  bit          m_owed;
  int          m_code;
  logic [31:0] m_ret_pc;

  task automatic model_reset();
    e_take = 0; e_wfi_stall = 0; e_in_trap = 0;
    e_cause = 0; e_epc = 0; e_target = 0; e_cnt = 0;
    m_owed = 0; m_code = 0; m_ret_pc = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit pe, ps, pt, any, go;
    int code;
    pe   = ext_irq & mie_meie;
    ps   = sw_irq & mie_msie;
    pt   = tmr_irq & mie_mtie;
    any  = pe | ps | pt;
    go   = !im_stall && !dm_stall;
    code = pe ? 11 : ps ? 3 : pt ? 7 : 0;
    if (e_take) begin
      e_take    = 0;
      e_in_trap = 1;
    end else if (e_in_trap) begin
      if (mret_valid && go) e_in_trap = 0;
    end else if (m_owed) begin
      if (go) begin
        m_owed   = 0;
        e_take   = 1;
        e_epc    = m_ret_pc;
        e_cause  = 32'h8000_0000 + 32'(m_code);
        e_target = IsrPc;
        e_cnt    = e_cnt + 1;
      end
    end else if (e_wfi_stall) begin
      if (any) begin
        e_wfi_stall = 0;
        if (mstatus_mie) begin
          m_owed = 1;
          m_code = code;
        end
      end
    end else if (go) begin
      if (any && mstatus_mie) begin
        m_owed   = 1;
        m_code   = code;
        m_ret_pc = wfi_valid ? exe_pc + 4 : exe_pc;
      end else if (wfi_valid) begin
        e_wfi_stall = 1;
        m_ret_pc    = exe_pc + 4;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("trap_take", trap_take, e_take);
    check_eq("flush", flush, e_take);
    check_eq("wfi_stall", wfi_stall, e_wfi_stall);
    check_eq("in_trap", in_trap, e_in_trap);
    check_eq("trap_cause", trap_cause, e_cause);
    check_eq("trap_epc", trap_epc, e_epc);
    check_eq("trap_target", trap_target, e_target);
    check_eq("trap_cnt", trap_cnt, e_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_take(input int max_cycles, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (trap_take) seen = 1;
    end
  endtask

  task automatic finish_handler();
    tick();
    mret_valid = 1;
    tick();
    mret_valid = 0;
  endtask

  initial begin
    bit seen;
    logic [31:0] cnt_before;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    compare_all();
    rst = 1;
    tick();

    // Single external interrupt: DRAIN after one edge, trap_take after the second.
    mstatus_mie = 1; mie_meie = 1; exe_pc = 32'h100; ext_irq = 1;
    tick();
    check_eq("t1_no_take_yet", trap_take, 0);
    ext_irq = 0;
    tick();
    check_eq("t1_take", trap_take, 1);
    check_eq("t1_cause", trap_cause, 32'h8000_000B);
    check_eq("t1_epc", trap_epc, 32'h100);
    check_eq("t1_target", trap_target, 32'h0001_0000);
    check_eq("t1_cnt", trap_cnt, 1);
    finish_handler();

    // External and timer together, external wins; timer traps after mret.
    mie_mtie = 1; ext_irq = 1; tmr_irq = 1;
    wait_take(4, seen);
    check_eq("t2_seen_ext", seen, 1);
    check_eq("t2_cause_ext", trap_cause, 32'h8000_000B);
    ext_irq = 0;
    finish_handler();
    wait_take(6, seen);
    check_eq("t2_seen_tmr", seen, 1);
    check_eq("t2_cause_tmr", trap_cause, 32'h8000_0007);
    tmr_irq = 0;
    finish_handler();

    // WFI sleep, then wake by an external interrupt.
    exe_pc = 32'h200; wfi_valid = 1;
    tick();
    wfi_valid = 0; exe_pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_sleeping", wfi_stall, 1);
      tick();
    end
    ext_irq = 1;
    wait_take(4, seen);
    check_eq("t3_seen", seen, 1);
    check_eq("t3_epc", trap_epc, 32'h204);
    ext_irq = 0;
    finish_handler();

    // WFI wake with MIE off: no trap.
    mstatus_mie = 0; exe_pc = 32'h280; wfi_valid = 1;
    tick();
    wfi_valid = 0;
    tick();
    check_eq("t4_sleeping", wfi_stall, 1);
    cnt_before = trap_cnt;
    tmr_irq = 1;
    tick();
    check_eq("t4_woken", wfi_stall, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_no_take", trap_take, 0);
    end
    check_eq("t4_cnt_same", trap_cnt, cnt_before);
    tmr_irq = 0; mstatus_mie = 1;
    tick();

    // Request followed by a 4-cycle data stall: DRAIN holds.
    exe_pc = 32'h400; ext_irq = 1;
    tick();
    ext_irq = 0; dm_stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t5_held", trap_take, 0);
    end
    dm_stall = 0;
    tick();
    check_eq("t5_take", trap_take, 1);
    check_eq("t5_epc", trap_epc, 32'h400);
    finish_handler();

    // Reset while in DRAIN.
    exe_pc = 32'h500; ext_irq = 1;
    tick();
    ext_irq = 0;
    rst = 0;
    #1;
    model_reset();
    compare_all();
    #2;
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t6_no_take", trap_take, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ext_irq     = ($urandom_range(0, 9) == 0);
      tmr_irq     = ($urandom_range(0, 9) == 0);
      sw_irq      = ($urandom_range(0, 9) == 0);
      mstatus_mie = ($urandom_range(0, 3) != 0);
      mie_meie    = ($urandom_range(0, 3) != 0);
      mie_mtie    = ($urandom_range(0, 3) != 0);
      mie_msie    = ($urandom_range(0, 3) != 0);
      im_stall    = ($urandom_range(0, 4) == 0);
      dm_stall    = ($urandom_range(0, 4) == 0);
      exe_pc      = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      wfi_valid   = ($urandom_range(0, 9) == 0);
      mret_valid  = !wfi_valid && ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
